// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter: ARP, PING and UDP builders share one MAC TX stream.
// Optional stall watchdog is compiled in when ETH_TX_WDOG_EN is defined.
module eth_tx_arbiter #(
  parameter int DATA_W      = 32,
  parameter int IFG_CYCLES  = 2,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arp_req,
  input  logic [DATA_W-1:0] i_arp_data,
  input  logic              i_arp_sop,
  input  logic              i_arp_eop,
  input  logic              i_arp_vld,
  output logic              o_arp_rdy,
  input  logic              i_ping_req,
  input  logic [DATA_W-1:0] i_ping_data,
  input  logic              i_ping_sop,
  input  logic              i_ping_eop,
  input  logic              i_ping_vld,
  output logic              o_ping_rdy,
  input  logic              i_udp_req,
  input  logic [DATA_W-1:0] i_udp_data,
  input  logic              i_udp_sop,
  input  logic              i_udp_eop,
  input  logic              i_udp_vld,
  output logic              o_udp_rdy,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_sop,
  output logic              o_out_eop,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  output logic [2:0]        o_grant,
  output logic              o_busy,
  output logic              o_abort
);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  state_t             state_reg, state_next;
  logic [2:0]         grant_reg, grant_next;
  logic [1:0]         rr_ptr_reg, rr_ptr_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               abort_reg, abort_next;
  logic               busy_reg;

  logic [2:0]         req_vec, vld_vec, sop_vec, eop_vec, rdy_vec;
  logic [DATA_W-1:0]  data_arr [3];
  logic [DATA_W-1:0]  data_msk [3];
  logic               accept, eop_acc, wdog_hit;
  logic               win_found;
  logic [1:0]         win_idx;
  logic [2:0]         cand;

  assign req_vec     = {i_udp_req, i_ping_req, i_arp_req};
  assign vld_vec     = {i_udp_vld, i_ping_vld, i_arp_vld};
  assign sop_vec     = {i_udp_sop, i_ping_sop, i_arp_sop};
  assign eop_vec     = {i_udp_eop, i_ping_eop, i_arp_eop};
  assign data_arr[0] = i_arp_data;
  assign data_arr[1] = i_ping_data;
  assign data_arr[2] = i_udp_data;

  // Zero-latency datapath: AND-OR mux steered by the registered one-hot grant.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_src
      assign data_msk[gi] = grant_reg[gi] ? data_arr[gi] : '0;
      assign rdy_vec[gi]  = grant_reg[gi] & i_out_rdy;
    end
  endgenerate

  assign o_out_data = data_msk[0] | data_msk[1] | data_msk[2];
  assign o_out_vld  = |(grant_reg & vld_vec);
  assign o_out_sop  = |(grant_reg & sop_vec);
  assign o_out_eop  = |(grant_reg & eop_vec);
  assign o_arp_rdy  = rdy_vec[0];
  assign o_ping_rdy = rdy_vec[1];
  assign o_udp_rdy  = rdy_vec[2];
  assign o_grant    = grant_reg;
  assign o_busy     = busy_reg;
  assign o_abort    = abort_reg;

  assign accept  = o_out_vld & i_out_rdy;
  assign eop_acc = accept & o_out_eop;

`ifdef ETH_TX_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES);
  logic [WDOG_W-1:0] wdog_cnt_reg;

  // Fires on the stall cycle that would bring the count to WDOG_CYCLES-1.
  assign wdog_hit = (state_reg == XFER) && !accept &&
                    (wdog_cnt_reg == WDOG_W'(WDOG_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (rst || state_reg != XFER || accept) begin
      wdog_cnt_reg <= '0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
    end
  end
`else
  assign wdog_hit = (WDOG_CYCLES < 0);
`endif

  // First requester at or after rr_ptr in cyclic order ARP, PING, UDP.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr_reg} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!win_found && req_vec[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_ptr_next  = rr_ptr_reg;
    gap_cnt_next = gap_cnt_reg;
    abort_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next  = 3'b001 << win_idx;
          rr_ptr_next = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
          state_next  = XFER;
        end
      end
      XFER: begin
        if (eop_acc || wdog_hit) begin
          grant_next = 3'b000;
          abort_next = wdog_hit;
          if (IFG_CYCLES == 0) begin
            state_next = IDLE;
          end else begin
            state_next   = GAP;
            gap_cnt_next = GAP_W'(IFG_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      grant_reg   <= 3'b000;
      rr_ptr_reg  <= 2'd0;
      gap_cnt_reg <= '0;
      abort_reg   <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_ptr_reg  <= rr_ptr_next;
      gap_cnt_reg <= gap_cnt_next;
      abort_reg   <= abort_next;
      busy_reg    <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: packet-level model checked every cycle plus directed literals.
module tb_eth_tx_arbiter;
  localparam int DW  = 32;
  localparam int IFG = 2;
  localparam int WD  = 16;
`ifdef ETH_TX_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [2:0]    req_v, vld_v, sop_v, eop_v, rdy_v;
  logic [DW-1:0] data_s [3];
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_sop, out_eop, out_vld, busy, abort;
  logic [2:0]    grant;

  eth_tx_arbiter #(.DATA_W(DW), .IFG_CYCLES(IFG), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst),
    .i_arp_req(req_v[0]), .i_arp_data(data_s[0]), .i_arp_sop(sop_v[0]),
    .i_arp_eop(eop_v[0]), .i_arp_vld(vld_v[0]), .o_arp_rdy(rdy_v[0]),
    .i_ping_req(req_v[1]), .i_ping_data(data_s[1]), .i_ping_sop(sop_v[1]),
    .i_ping_eop(eop_v[1]), .i_ping_vld(vld_v[1]), .o_ping_rdy(rdy_v[1]),
    .i_udp_req(req_v[2]), .i_udp_data(data_s[2]), .i_udp_sop(sop_v[2]),
    .i_udp_eop(eop_v[2]), .i_udp_vld(vld_v[2]), .o_udp_rdy(rdy_v[2]),
    .o_out_data(out_data), .o_out_sop(out_sop), .o_out_eop(out_eop),
    .o_out_vld(out_vld), .i_out_rdy(out_rdy),
    .o_grant(grant), .o_busy(busy), .o_abort(abort)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tmo(input string name, input int bound);
    checks++;
    $display("FAIL %s: event not seen, required within %0d cycles", name, bound);
  endtask

  // Packet-level model: owner of the stream, remaining gap cycles, round-robin pointer.
  bit  model_on = 1'b0;
  int  owner = -1, gap_rem = 0, rr = 0, stall = 0, cyc = 0;
  bit  abort_exp = 1'b0;
  int  gnt_src_q[$], gnt_cyc_q[$], eop_cyc_q[$];
  logic [DW-1:0] beat_q[$];
  logic [2:0] prev_grant = 3'b000;

  always @(negedge clk) begin
    logic [2:0] eg;
    logic       ev;
    int         s;
    if (model_on) begin
      eg = (owner >= 0) ? 3'(1 << owner) : 3'b000;
      ev = (owner >= 0) ? vld_v[owner] : 1'b0;
      chk("grant", grant, eg);
      chk("busy", busy, (owner >= 0) || (gap_rem > 0));
      chk("abort", abort, abort_exp);
      chk("out_vld", out_vld, ev);
      chk("src_rdy", rdy_v, eg & {3{out_rdy}});
      if (ev)
        chk("out_beat", {out_sop, out_eop, out_data},
            {sop_v[owner], eop_v[owner], data_s[owner]});

      if (grant != 3'b000 && grant != prev_grant) begin
        gnt_src_q.push_back(grant[0] ? 0 : (grant[1] ? 1 : 2));
        gnt_cyc_q.push_back(cyc);
      end
      if (out_vld && out_rdy) begin
        beat_q.push_back(out_data);
        if (out_eop) eop_cyc_q.push_back(cyc);
      end
      prev_grant = grant;

      abort_exp = 1'b0;
      if (rst) begin
        owner = -1; gap_rem = 0; rr = 0; stall = 0;
      end else if (owner >= 0) begin
        if (vld_v[owner] && out_rdy) begin
          stall = 0;
          if (eop_v[owner]) begin owner = -1; gap_rem = IFG; end
        end else begin
          stall++;
          if (WDOG_ON && stall == WD - 1) begin
            owner = -1; gap_rem = IFG; abort_exp = 1'b1;
          end
        end
      end else if (gap_rem > 0) begin
        gap_rem--;
      end else begin
        for (int k = 0; k < 3; k++) begin
          s = (rr + k) % 3;
          if (owner < 0 && req_v[s]) owner = s;
        end
        if (owner >= 0) begin rr = (owner + 1) % 3; stall = 0; end
      end
      cyc++;
    end
  end

  task automatic send_pkt(input int s, input int n, input logic [DW-1:0] base);
    int  t, i;
    bit  acc;
    req_v[s] = 1'b1;
    t = 0;
    while (!grant[s]) begin
      @(posedge clk); #1;
      t++;
      if (t > 200) begin tmo("grant_wait", 200); req_v[s] = 1'b0; return; end
    end
    req_v[s] = 1'b0;
    i = 0; t = 0;
    while (i < n) begin
      vld_v[s] = 1'b1; sop_v[s] = (i == 0); eop_v[s] = (i == n - 1);
      data_s[s] = base + DW'(i);
      @(negedge clk); acc = rdy_v[s];
      @(posedge clk); #1;
      if (acc) i++;
      t++;
      if (t > 200) begin tmo("beat_wait", 200); i = n; end
    end
    vld_v[s] = 1'b0; sop_v[s] = 1'b0; eop_v[s] = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, required to end earlier");
    $fatal(1);
  end

  initial begin
    int r, m, k, t;
    rst = 1'b1; req_v = '0; vld_v = '0; sop_v = '0; eop_v = '0; out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) data_s[i] = '0;
    @(posedge clk); #1;
    model_on = 1'b1;
    @(negedge clk);
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_abort", abort, 1'b0);
    chk("rst_vld", out_vld, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // 1: single ARP 3-beat packet
    m = beat_q.size(); k = gnt_src_q.size(); r = cyc;
    send_pkt(0, 3, 32'hA000_0010);
    chk("t1_grant_src", gnt_src_q[k], 0);
    chk("t1_grant_lat", gnt_cyc_q[k] - r, 1);
    chk("t1_nbeats", beat_q.size() - m, 3);
    chk("t1_beat0", beat_q[m], 32'hA000_0010);
    chk("t1_beat2", beat_q[m+2], 32'hA000_0012);
    @(negedge clk); chk("t1_busy_gap0", busy, 1'b1);
    @(negedge clk); chk("t1_busy_gap1", busy, 1'b1);
    @(negedge clk); chk("t1_busy_idle", busy, 1'b0);
    @(posedge clk); #1;

    // 2: all three request together after a reset, rr starts at ARP
    pulse_rst();
    k = gnt_src_q.size();
    fork
      begin send_pkt(0, 1, 32'hA100_0000); send_pkt(0, 1, 32'hA100_0001); end
      send_pkt(1, 1, 32'hB100_0000);
      send_pkt(2, 1, 32'hC100_0000);
    join
    chk("t2_order0", gnt_src_q[k], 0);
    chk("t2_order1", gnt_src_q[k+1], 1);
    chk("t2_order2", gnt_src_q[k+2], 2);
    chk("t2_order3", gnt_src_q[k+3], 0);
    chk("t2_spacing1", gnt_cyc_q[k+1] - gnt_cyc_q[k], IFG + 2);
    chk("t2_spacing3", gnt_cyc_q[k+3] - gnt_cyc_q[k+2], IFG + 2);
    repeat (5) begin @(posedge clk); #1; end

    // 3: UDP 4 beats with MAC back-pressure on beats 2-3
    m = beat_q.size();
    fork
      send_pkt(2, 4, 32'hC300_0000);
      begin
        t = 0;
        while (!grant[2] && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) tmo("t3_grant", 200);
        @(posedge clk); #1; out_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1; out_rdy = 1'b1;
      end
    join
    chk("t3_nbeats", beat_q.size() - m, 4);
    chk("t3_beat0", beat_q[m], 32'hC300_0000);
    chk("t3_beat1", beat_q[m+1], 32'hC300_0001);
    chk("t3_beat3", beat_q[m+3], 32'hC300_0003);
    repeat (5) begin @(posedge clk); #1; end

    // 4: ARP request arrives while PING owns the stream
    k = gnt_src_q.size();
    fork
      send_pkt(1, 4, 32'hB400_0000);
      begin
        t = 0;
        while (!grant[1] && t < 200) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        send_pkt(0, 2, 32'hA400_0000);
      end
    join
    chk("t4_first", gnt_src_q[k], 1);
    chk("t4_second", gnt_src_q[k+1], 0);
    chk("t4_after_eop", gnt_cyc_q[k+1] - eop_cyc_q[eop_cyc_q.size()-2], IFG + 2);
    repeat (5) begin @(posedge clk); #1; end

    // 5: reset during beat 2 of a UDP packet
    req_v[2] = 1'b1;
    t = 0;
    while (!grant[2] && t < 200) begin @(posedge clk); #1; t++; end
    req_v[2] = 1'b0;
    vld_v[2] = 1'b1; sop_v[2] = 1'b1; data_s[2] = 32'hC500_0000;
    @(posedge clk); #1;
    sop_v[2] = 1'b0; data_s[2] = 32'hC500_0001;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_grant", grant, 3'b000);
    chk("t5_vld", out_vld, 1'b0);
    chk("t5_udp_rdy", rdy_v[2], 1'b0);
    @(posedge clk); #1;
    vld_v[2] = 1'b0;
    k = gnt_src_q.size();
    fork
      send_pkt(1, 1, 32'hB500_0000);
      send_pkt(2, 1, 32'hC500_0002);
    join
    chk("t5_rr_first", gnt_src_q[k], 1);
    repeat (5) begin @(posedge clk); #1; end

`ifdef ETH_TX_WDOG_EN
    // 6: ARP stalls after sop; watchdog drops it and PING is served
    req_v[0] = 1'b1;
    t = 0;
    while (!grant[0] && t < 200) begin @(posedge clk); #1; t++; end
    req_v[0] = 1'b0;
    vld_v[0] = 1'b1; sop_v[0] = 1'b1; data_s[0] = 32'hA600_0000;
    @(posedge clk); #1;
    vld_v[0] = 1'b0; sop_v[0] = 1'b0;
    k = gnt_src_q.size();
    fork
      send_pkt(1, 1, 32'hB600_0000);
      begin
        t = 1;
        while (t < 40) begin
          @(negedge clk);
          if (abort) break;
          @(posedge clk); #1;
          t++;
        end
        if (t >= 40) tmo("t6_abort", 40);
        else begin
          chk("t6_abort_delay", t, 16);
          chk("t6_grant_clr", grant, 3'b000);
        end
      end
    join
    chk("t6_ping_served", gnt_src_q[k], 1);
    repeat (5) begin @(posedge clk); #1; end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
